i2c_slave_regbank: RTL and testbench

I2C_SLAVE_REGBANK -- requirements
Module: i2c_slave_regbank

---
 rtl/i2c_slave_regbank.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// rtl/i2c_slave_regbank.sv - I2C slave exposing a byte-wide register bank with auto-incrementing pointer
// Pointer byte selects a register; following bytes write (or reads stream) from it.
module i2c_slave_regbank #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MEM_DEPTH  = 128,
    parameter int         PTR_W      = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             stretch,
    output logic             busy,
    output logic             wr_pulse,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             nack_err,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
    logic [2:0] scl_sync_q, sda_sync_q;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sr_q, sr_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             scl_oe_q, scl_oe_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             nack_err_q, nack_err_d;
    logic             done_q, done_d;
    logic [7:0]       mem_q [MEM_DEPTH];
    logic [7:0]       mem_d [MEM_DEPTH];

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, ack_end, in_read;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
    assign stop_det  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;
    assign in_read   = (state_q == RDATA) || (state_q == RDATA_ACK);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q & stretch;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        nack_err_d = nack_err_q;
        done_d     = 1'b0;
        mem_d      = mem_q;
        ack_end    = 1'b0;

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            done_d   = busy_q;
            busy_d   = 1'b0;
            if (in_read) nack_err_d = 1'b1;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            if (in_read) nack_err_d = 1'b1;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sr_d      = {sr_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        if (state_q == ADDR) begin
                            if (sr_q[7:1] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = WAIT_STOP;
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                            ptr_d   = sr_q[PTR_W-1:0];
                        end else begin
                            state_d       = WDATA_ACK;
                            mem_d[ptr_q]  = sr_q;
                            wr_pulse_d    = 1'b1;
                            wr_addr_d     = ptr_q;
                            wr_data_d     = sr_q;
                            ptr_d         = ptr_q + PTR_W'(1);
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        ack_end   = 1'b1;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR_ACK && sr_q[0]) begin
                            state_d  = RDATA;
                            sr_d     = mem_q[ptr_q];
                            sda_oe_d = ~mem_q[ptr_q][7];
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = RDATA_ACK;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        sr_d     = {sr_q[6:0], 1'b0};
                        sda_oe_d = ~sr_q[6];
                    end
                end
                RDATA_ACK: begin
                    // Pointer advances on the master's ACK/NACK bit; NACK ends the read cleanly.
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        ptr_d     = ptr_q + PTR_W'(1);
                        if (sda_s) begin
                            state_d    = WAIT_STOP;
                            nack_err_d = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        ack_end   = 1'b1;
                        state_d   = RDATA;
                        bit_cnt_d = 4'd0;
                        sr_d      = mem_q[ptr_q];
                        sda_oe_d  = ~mem_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
            if (ack_end && stretch) scl_oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            sr_q       <= 8'd0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            nack_err_q <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'(i);
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            nack_err_q <= nack_err_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
        end
    end

    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign nack_err = nack_err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb/tb_i2c_slave_regbank.sv - bit-level I2C master with register-bank reference model
module tb_i2c_slave_regbank;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1, stretch = 1'b0;
    logic       scl_i, sda_i, scl_oe, sda_oe, busy, wr_pulse, nack_err, done;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    // open-drain bus: either side may pull a line low
    assign scl_i = scl_m & ~scl_oe;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_regbank dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .stretch(stretch), .busy(busy), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .wr_data(wr_data), .nack_err(nack_err), .done(done)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] ref_mem [128];
    int         ref_ptr;
    function automatic void ref_reset();
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
        ref_ptr = 0;
    endfunction

    logic [14:0] wr_log[$];
    int          done_cnt = 0;
    bit          sda_seen = 0, busy_seen = 0;
    always @(negedge clk) begin
        if (wr_pulse) wr_log.push_back({wr_addr, wr_data});
        if (done) done_cnt++;
        if (sda_oe) sda_seen = 1;
        if (busy) busy_seen = 1;
    end

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        scl_m = 1'b1;
        for (int i = 0; i < 3000 && !scl_i; i++) begin
            @(posedge clk);
            #1;
        end
        if (!scl_i) chk("scl_release", scl_i, 1);
    endtask

    task automatic clk_bit(input bit b, output bit r);
        sda_m = b; wq();
        scl_high(); wq();
        r = sda_i; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_high(); wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_high(); wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input bit nack, output logic [7:0] b);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            b[i] = r;
        end
        clk_bit(nack, r);
    endtask

    logic [7:0] tx_data[$];
    task automatic do_write(input logic [7:0] p);
        bit          a;
        int          d0;
        logic [14:0] exp[$];
        wr_log.delete();
        d0 = done_cnt;
        i2c_start();
        send_byte(8'hA0, a); chk("wr_addr_ack", a, 0);
        send_byte(p, a);     chk("wr_ptr_ack", a, 0);
        ref_ptr = p % 128;
        foreach (tx_data[i]) begin
            send_byte(tx_data[i], a); chk("wr_data_ack", a, 0);
            exp.push_back({7'(ref_ptr), tx_data[i]});
            ref_mem[ref_ptr] = tx_data[i];
            ref_ptr = (ref_ptr + 1) % 128;
        end
        i2c_stop(); wq();
        chk("wr_count", wr_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk("wr_event", (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hdead, 32'(exp[i]));
        chk("wr_done", done_cnt - d0, 1);
    endtask

    // p < 0 reads from the retained pointer; otherwise pointer write then repeated START
    task automatic do_read(input int p, input int n);
        bit         a;
        logic [7:0] b;
        i2c_start();
        if (p >= 0) begin
            send_byte(8'hA0, a);   chk("rd_waddr_ack", a, 0);
            send_byte(8'(p), a);   chk("rd_ptr_ack", a, 0);
            ref_ptr = p % 128;
            i2c_start();
        end
        send_byte(8'hA1, a); chk("rd_addr_ack", a, 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            chk("rd_data", b, ref_mem[ref_ptr]);
            ref_ptr = (ref_ptr + 1) % 128;
        end
        i2c_stop(); wq();
        chk("rd_nack_err", nack_err, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         a, r;
        int         d0, hold;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {scl_oe, sda_oe, busy, wr_pulse, nack_err, done}, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        wq();

        // write burst, then confirm the pointer landed on 7
        tx_data = '{8'h11, 8'h22};
        do_write(8'h05);
        do_read(-1, 1);

        // combined read wrapping at the top of the bank
        do_read(8'h7F, 2);

        // foreign address: never driven, never busy
        sda_seen = 0; busy_seen = 0; wr_log.delete(); d0 = done_cnt;
        i2c_start();
        send_byte(8'hA2, a); chk("mis_nack", a, 1);
        send_byte(8'h05, a);
        send_byte(8'h33, a);
        i2c_stop(); wq();
        chk("mis_sda_driven", sda_seen, 0);
        chk("mis_busy", busy_seen, 0);
        chk("mis_wr", wr_log.size(), 0);
        chk("mis_done", done_cnt - d0, 0);

        // clock stretch on the address ACK
        stretch = 1'b1;
        tx_data = '{8'h5A, 8'hC3};
        fork
            do_write(8'h10);
            begin
                for (int i = 0; i < 3000 && !scl_oe; i++) @(negedge clk);
                chk("stretch_assert", scl_oe, 1);
                hold = 0;
                repeat (500) begin
                    @(negedge clk);
                    if (scl_oe) hold++;
                end
                chk("stretch_hold", hold, 500);
                @(posedge clk); #1;
                stretch = 1'b0;
                @(posedge clk); #1;
                chk("stretch_release", scl_oe, 0);
            end
        join
        do_read(8'h10, 2);

        // STOP in the middle of a read byte
        tx_data = '{8'hFF};
        do_write(8'h30);
        d0 = done_cnt;
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h30, a);
        i2c_start();
        send_byte(8'hA1, a);
        for (int i = 0; i < 3; i++) begin
            clk_bit(1'b1, r);
            chk("abort_bit", r, 1);
        end
        i2c_stop(); wq();
        chk("abort_nack_err", nack_err, 1);
        chk("abort_lines", {scl_oe, sda_oe}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done_cnt - d0, 1);

        // reset after 4 data bits of a write
        wr_log.delete();
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h22, a);
        for (int i = 0; i < 4; i++) clk_bit(i[0], r);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_lines", {scl_oe, sda_oe}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_reset();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
        chk("rst_mid_wr", wr_log.size(), 0);
        do_read(-1, 1);
        do_read(8'h22, 1);

        // randomized bursts against the model
        for (int it = 0; it < 5; it++) begin
            tx_data.delete();
            repeat ($urandom_range(1, 4)) tx_data.push_back(8'($urandom));
            do_write(8'($urandom_range(0, 255)));
            do_read($urandom_range(0, 255), $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) do_read(-1, 2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
